// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the dual-clock FIFO read side.
//   DATA_SIZE_DEF : default word width
//   STAT_W        : width of the statistics counters
//   occ_t         : skid buffer occupancy (EMPTY / ONE / TWO)
package fifo_pkg;
    localparam int DATA_SIZE_DEF = 12;
    localparam int STAT_W = 32;
    typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry register skid buffer with occupancy FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din into the buffer this edge
//   pull       : head consumed this edge
//   occ, head  : current occupancy and oldest word
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pull,
    input  logic [DATA_SIZE-1:0] din,
    output occ_t                 occ,
    output logic [DATA_SIZE-1:0] head
);
    occ_t occ_q, occ_d;
    logic [DATA_SIZE-1:0] head_q, head_d, tail_q, tail_d;

    always_comb begin
        occ_d = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    occ_d = OCC_ONE;
                    head_d = din;
                end
            end
            OCC_ONE: begin
                if (push && pull) begin
                    head_d = din;
                end else if (push) begin
                    occ_d = OCC_TWO;
                    tail_d = din;
                end else if (pull) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pull) begin
                    head_d = tail_q;
                    occ_d = push ? OCC_TWO : OCC_ONE;
                    if (push) tail_d = din;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ = occ_q;
    assign head = head_q;

    overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && occ_q == OCC_TWO && !pull));
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: converts the FIFO one-cycle-latency pop port into a valid/ready stream.
//   rclk, rrst           : read clock, asynchronous active-low reset
//   rEmpty, rData, rinc  : FIFO read port
//   out_valid/ready/data : downstream stream
//   rd_count, stall_count: delivered words / backpressure cycles (only with FIFO_RD_STATS_EN)
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rEmpty,
    input  logic [DATA_SIZE-1:0] rData,
    output logic                 rinc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [STAT_W-1:0]    rd_count,
    output logic [STAT_W-1:0]    stall_count
`endif
);
    logic inflight_q, inflight_d, pull;
    logic [2:0] load;
    occ_t occ;

    fifo_rd_skid #(.DATA_SIZE(DATA_SIZE)) u_skid (
        .clk(rclk),
        .rst_n(rrst),
        .push(inflight_q),
        .pull(pull),
        .din(rData),
        .occ(occ),
        .head(out_data)
    );

    // load = words that will occupy the buffer after this edge, counting the in-flight pop
    always_comb begin
        out_valid = occ != OCC_EMPTY;
        pull = out_valid && out_ready;
        load = 3'(occ) + 3'(inflight_q) - 3'(pull);
        rinc = rrst && !rEmpty && load < 3'd2;
        inflight_d = rinc && !rEmpty;
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) inflight_q <= 1'b0;
        else inflight_q <= inflight_d;
    end

`ifdef FIFO_RD_STATS_EN
    logic [STAT_W-1:0] rd_count_q, rd_count_d, stall_count_q, stall_count_d;

    always_comb begin
        rd_count_d = rd_count_q + STAT_W'(pull);
        stall_count_d = (out_valid && !out_ready && stall_count_q != '1) ? stall_count_q + STAT_W'(1) : stall_count_q;
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            rd_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign stall_count = stall_count_q;
`endif
endmodule
